mult_result_buffer: RTL and testbench
=====================================

MULT_RESULT_BUFFER -- requirements
Module: mult_result_buffer

Interface
REQ-001 The block SHALL have parameter DW, default 16, meaning the product width, matching the 16-bit multiplier o_product.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning the number of FIFO entries; legal values are powers of 2 and at least 2.
REQ-003 The block SHALL have port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port i_rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port i_stop, input, 1 bit: multiplier done indication; it is a level that may be held high for several cycles.
REQ-006 The block SHALL have port i_product, input, DW bits: multiplier result, valid while i_stop is high.
REQ-007 The block SHALL have port i_ready, input, 1 bit: consumer accepts the head entry.
REQ-008 The block SHALL have port i_clr_ovf, input, 1 bit: synchronous clear of o_overflow.
REQ-009 The block SHALL have port o_data, output, DW bits: head entry (first-word-fall-through).
REQ-010 The block SHALL have port o_valid, output, 1 bit: o_data holds a valid entry.
REQ-011 The block SHALL have port o_count, output, $clog2(DEPTH)+1 bits: number of stored entries.
REQ-012 The block SHALL have port o_full, output, 1 bit: o_count equals DEPTH.
REQ-013 The block SHALL have port o_empty, output, 1 bit: o_count equals 0.
REQ-014 The block SHALL have port o_overflow, output, 1 bit: sticky flag for a dropped product.

Function
REQ-015 The block SHALL register i_stop into stop_q every cycle and detect a capture event as i_stop high with stop_q low (rising edge).
REQ-016 On a capture event, the block SHALL write i_product to the tail entry at that clock edge, and o_valid SHALL be high from the next cycle onward.
REQ-017 Holding i_stop high for N cycles SHALL produce exactly one write.
REQ-018 A pop SHALL occur on a clock edge where o_valid and i_ready are both high; it advances the head entry.
REQ-019 i_ready while the FIFO is empty SHALL be ignored, with no pointer or count change.
REQ-020 o_data SHALL equal the head entry when o_valid is high and SHALL be 0 when the FIFO is empty.
REQ-021 Capture while the FIFO is not full SHALL increment o_count.
REQ-022 A pop without a capture SHALL decrement o_count.
REQ-023 A capture and a pop on the same edge SHALL leave o_count unchanged, and both operations SHALL take effect.
REQ-024 A capture while full and without a pop SHALL drop the product, leave the entries unchanged, and set o_overflow.
REQ-025 A capture while full with a simultaneous pop SHALL be accepted, with no overflow.
REQ-026 Read and write pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-027 o_full, o_empty and o_valid SHALL be decoded from the registered count, giving no combinational path from inputs.
REQ-028 o_overflow SHALL remain set until i_clr_ovf is high at a clock edge.
REQ-029 If i_clr_ovf and a new overflow occur on the same edge, o_overflow SHALL be set (set wins).

Reset
REQ-030 While i_rst is low, the block SHALL immediately, without a clock, set pointers to 0, o_count to 0, o_empty to 1, o_full to 0, o_valid to 0, o_data to 0, o_overflow to 0 and stop_q to 0.
REQ-031 Stored entry contents need not be cleared by reset.
REQ-032 Reset asserted mid-operation SHALL discard all entries.
REQ-033 If i_stop is high at the first edge after reset release, the block SHALL treat it as a capture event, because stop_q is 0.

Verification
REQ-034 The bench SHALL cover this scenario: reset, then i_ready=0 and three i_stop pulses with products 1200, 240, 3200 -> o_count=3; then raise i_ready -> o_data reads 1200, 240, 3200 on consecutive cycles, then o_empty=1 and o_data=0.
REQ-035 The bench SHALL cover this scenario: i_stop held high 5 cycles with i_product=1200 -> exactly one entry, o_count=1.
REQ-036 The bench SHALL cover this scenario: i_ready=0 and 5 captures (values 1..5) at DEPTH=4 -> o_full=1, o_overflow=1; the drained values are 1,2,3,4; o_overflow stays 1 until an i_clr_ovf pulse clears it.
REQ-037 The bench SHALL cover this scenario: FIFO full with i_ready=1 and a capture of 99 on the same edge -> o_count stays 4, o_overflow=0, and 99 appears after the next three entries.
REQ-038 The bench SHALL cover this scenario: i_rst driven low asynchronously between clock edges with o_count=2 -> o_count=0, o_valid=0 and o_data=0 before the next rising edge.
REQ-039 The bench SHALL cover this scenario: more than DEPTH push/pop cycles alternating (for example 10 products 100..109) -> output order matches input order across pointer wrap.

Source files
------------

// File: rtl/mult_result_buffer.sv
// Result FIFO behind a multiplier: captures one product per rising edge of
// i_stop and presents the oldest entry first-word-fall-through.
module mult_result_buffer #(
  parameter int DW    = 16,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_stop,
  input  logic [DW-1:0]            i_product,
  input  logic                     i_ready,
  input  logic                     i_clr_ovf,
  output logic [DW-1:0]            o_data,
  output logic                     o_valid,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty,
  output logic                     o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          stop_q, stop_d;
  logic          ovf_q, ovf_d;

  logic capture;
  logic pop;
  logic full;
  logic empty;
  logic wr_en;
  logic drop;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  // Handshake: an entry leaves on a rising edge where o_valid and i_ready are
  // both high; o_data holds steady while o_valid is high and i_ready is low.
  always_comb begin
    capture  = i_stop & ~stop_q;
    pop      = ~empty & i_ready;
    wr_en    = capture & (~full | pop);
    drop     = capture & full & ~pop;
    stop_d   = i_stop;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    mem_d    = mem_q;

    if (wr_en) begin
      mem_d[wr_ptr_q] = i_product;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (wr_en && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !wr_en) begin
      count_d = count_q - CW'(1);
    end

    // A fresh drop on the same edge as a clear leaves the flag set.
    if (i_clr_ovf) begin
      ovf_d = 1'b0;
    end
    if (drop) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      stop_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      stop_q   <= stop_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is left out of reset; the zero count masks stale contents.
  always_ff @(posedge i_clk) begin
    mem_q <= mem_d;
  end

  assign o_data     = empty ? '0 : mem_q[rd_ptr_q];
  assign o_valid    = ~empty;
  assign o_count    = count_q;
  assign o_full     = full;
  assign o_empty    = empty;
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_mult_result_buffer.sv
// Bench for mult_result_buffer: scripted vector table, hand-written corner
// sequences and random traffic checked against a queue-based model.
module tb_mult_result_buffer;

  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_stop = 1'b0;
  logic [DW-1:0] i_product = '0;
  logic          i_ready = 1'b0;
  logic          i_clr_ovf = 1'b0;
  logic [DW-1:0] o_data;
  logic          o_valid;
  logic [CW-1:0] o_count;
  logic          o_full;
  logic          o_empty;
  logic          o_overflow;

  int errors = 0;
  int checks = 0;

  // Reference model: a plain queue of stored products plus two flags.
  logic [DW-1:0] exp_q[$];
  logic          m_prev_stop = 1'b0;
  logic          m_ovf = 1'b0;

  typedef struct {
    logic          stop;
    logic [DW-1:0] prod;
    logic          ready;
    logic [CW-1:0] e_count;
    logic [DW-1:0] e_data;
  } vec_t;

  vec_t vecs[10];

  mult_result_buffer #(.DW(DW), .DEPTH(DEPTH)) dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_stop     (i_stop),
    .i_product  (i_product),
    .i_ready    (i_ready),
    .i_clr_ovf  (i_clr_ovf),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_count    (o_count),
    .o_full     (o_full),
    .o_empty    (o_empty),
    .o_overflow (o_overflow)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic [DW-1:0] ed;
    int            sz;
    sz = exp_q.size();
    ed = (sz > 0) ? exp_q[0] : '0;
    check($sformatf("%s.count", tag), 32'(o_count), 32'(sz));
    check($sformatf("%s.data", tag), 32'(o_data), 32'(ed));
    check($sformatf("%s.valid", tag), 32'(o_valid), 32'(sz > 0));
    check($sformatf("%s.empty", tag), 32'(o_empty), 32'(sz == 0));
    check($sformatf("%s.full", tag), 32'(o_full), 32'(sz == DEPTH));
    check($sformatf("%s.ovf", tag), 32'(o_overflow), 32'(m_ovf));
  endtask

  // Driver: apply one cycle of inputs, advance the model, compare after the edge.
  task automatic tick(input logic stop, input logic [DW-1:0] prod, input logic ready,
                      input logic clr, input string tag);
    bit cap;
    bit pop;
    bit drop;
    i_stop    = stop;
    i_product = prod;
    i_ready   = ready;
    i_clr_ovf = clr;
    @(posedge clk);
    cap  = stop && !m_prev_stop;
    pop  = ready && (exp_q.size() > 0);
    drop = cap && (exp_q.size() == DEPTH) && !pop;
    if (pop) void'(exp_q.pop_front());
    if (cap && !drop) exp_q.push_back(prod);
    if (clr) m_ovf = 1'b0;
    if (drop) m_ovf = 1'b1;
    m_prev_stop = stop;
    #1;
    check_model(tag);
  endtask

  // Asserts reset between edges and checks the outputs clear before any edge.
  task automatic apply_reset(input string tag);
    #2;
    i_rst     = 1'b0;
    i_stop    = 1'b0;
    i_ready   = 1'b0;
    i_clr_ovf = 1'b0;
    i_product = '0;
    #1;
    check($sformatf("%s.rst_count", tag), 32'(o_count), 32'd0);
    check($sformatf("%s.rst_valid", tag), 32'(o_valid), 32'd0);
    check($sformatf("%s.rst_data", tag), 32'(o_data), 32'd0);
    check($sformatf("%s.rst_empty", tag), 32'(o_empty), 32'd1);
    check($sformatf("%s.rst_full", tag), 32'(o_full), 32'd0);
    check($sformatf("%s.rst_ovf", tag), 32'(o_overflow), 32'd0);
    exp_q.delete();
    m_prev_stop = 1'b0;
    m_ovf       = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    i_rst = 1'b1;
  endtask

  task automatic push(input logic [DW-1:0] val, input string tag);
    tick(1'b1, val, 1'b0, 1'b0, tag);
    tick(1'b0, '0, 1'b0, 1'b0, tag);
  endtask

  initial begin
    vecs[0] = '{1'b1, 16'd1200, 1'b0, 3'd1, 16'd1200};
    vecs[1] = '{1'b0, 16'd0,    1'b0, 3'd1, 16'd1200};
    vecs[2] = '{1'b1, 16'd240,  1'b0, 3'd2, 16'd1200};
    vecs[3] = '{1'b0, 16'd0,    1'b0, 3'd2, 16'd1200};
    vecs[4] = '{1'b1, 16'd3200, 1'b0, 3'd3, 16'd1200};
    vecs[5] = '{1'b0, 16'd0,    1'b0, 3'd3, 16'd1200};
    vecs[6] = '{1'b0, 16'd0,    1'b1, 3'd2, 16'd240};
    vecs[7] = '{1'b0, 16'd0,    1'b1, 3'd1, 16'd3200};
    vecs[8] = '{1'b0, 16'd0,    1'b1, 3'd0, 16'd0};
    vecs[9] = '{1'b0, 16'd0,    1'b1, 3'd0, 16'd0};

    // Three pulses with the consumer stalled, then drain in order.
    apply_reset("r0");
    for (int i = 0; i < 10; i++) begin
      tick(vecs[i].stop, vecs[i].prod, vecs[i].ready, 1'b0, $sformatf("tbl%0d", i));
      check($sformatf("tbl%0d.exp_count", i), 32'(o_count), 32'(vecs[i].e_count));
      check($sformatf("tbl%0d.exp_data", i), 32'(o_data), 32'(vecs[i].e_data));
    end
    check("tbl.empty_end", 32'(o_empty), 32'd1);

    // Level held for five cycles gives one entry.
    apply_reset("r1");
    for (int i = 0; i < 5; i++) tick(1'b1, 16'd1200, 1'b0, 1'b0, "hold");
    tick(1'b0, '0, 1'b0, 1'b0, "hold");
    check("hold.count", 32'(o_count), 32'd1);
    check("hold.data", 32'(o_data), 32'd1200);
    tick(1'b0, '0, 1'b1, 1'b0, "hold_drain");
    check("hold.drained", 32'(o_count), 32'd0);

    // Overflow: fifth capture is dropped, flag is sticky until cleared.
    apply_reset("r2");
    for (int v = 1; v <= 5; v++) push(DW'(v), "ovf_fill");
    check("ovf.full", 32'(o_full), 32'd1);
    check("ovf.flag", 32'(o_overflow), 32'd1);
    for (int v = 1; v <= 4; v++) begin
      check($sformatf("ovf.head%0d", v), 32'(o_data), 32'(v));
      tick(1'b0, '0, 1'b1, 1'b0, "ovf_drain");
      check("ovf.sticky", 32'(o_overflow), 32'd1);
    end
    check("ovf.empty", 32'(o_empty), 32'd1);
    tick(1'b0, '0, 1'b0, 1'b1, "ovf_clr");
    check("ovf.cleared", 32'(o_overflow), 32'd0);

    // Clear and a new overflow on the same edge: the set wins.
    for (int v = 0; v < 4; v++) push(DW'(50 + v), "setwin_fill");
    tick(1'b1, 16'd77, 1'b0, 1'b1, "setwin");
    check("setwin.flag", 32'(o_overflow), 32'd1);
    tick(1'b0, '0, 1'b0, 1'b1, "setwin_clr");
    check("setwin.cleared", 32'(o_overflow), 32'd0);

    // Capture while full with a simultaneous pop is accepted.
    apply_reset("r3");
    for (int v = 0; v < 4; v++) push(DW'(10 + v), "fp_fill");
    tick(1'b1, 16'd99, 1'b1, 1'b0, "fullpop");
    check("fullpop.count", 32'(o_count), 32'd4);
    check("fullpop.ovf", 32'(o_overflow), 32'd0);
    check("fullpop.h0", 32'(o_data), 32'd11);
    tick(1'b0, '0, 1'b1, 1'b0, "fp_drain");
    check("fullpop.h1", 32'(o_data), 32'd12);
    tick(1'b0, '0, 1'b1, 1'b0, "fp_drain");
    check("fullpop.h2", 32'(o_data), 32'd13);
    tick(1'b0, '0, 1'b1, 1'b0, "fp_drain");
    check("fullpop.h3", 32'(o_data), 32'd99);
    tick(1'b0, '0, 1'b1, 1'b0, "fp_drain");

    // Asynchronous reset with two entries stored.
    push(16'd5, "ar_fill");
    push(16'd6, "ar_fill");
    check("async.pre_count", 32'(o_count), 32'd2);
    apply_reset("async");

    // Capture on the first edge after release.
    apply_reset("r4");
    tick(1'b1, 16'd321, 1'b0, 1'b0, "first_edge");
    check("first_edge.count", 32'(o_count), 32'd1);
    tick(1'b0, '0, 1'b1, 1'b0, "first_edge");

    // Alternating push/pop across pointer wrap.
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, DW'(100 + i), 1'b0, 1'b0, "wrap_push");
      check($sformatf("wrap.head%0d", i), 32'(o_data), 32'(100 + i));
      tick(1'b0, '0, 1'b1, 1'b0, "wrap_pop");
    end

    // Random traffic against the model.
    apply_reset("r5");
    for (int i = 0; i < 400; i++) begin
      tick(1'($urandom_range(0, 1)), DW'($urandom_range(0, 16'hFFFF)),
           1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 15) == 0), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
